// File: rtl/qos_arb_pkg.sv
// qos_arb_pkg: shared types and helpers for the QoS arbiter slice.
//   arb_mode_e  - arbitration policy encoding carried on the 2-bit mode port
//   arb_state_e - grant FSM state (IDLE: no grant held, BUSY: grant held)
//   wrap_inc    - index + 1 modulo a channel count
package qos_arb_pkg;

    typedef enum logic [1:0] {
        ARB_RR    = 2'd0,
        ARB_FIXED = 2'd1,
        ARB_WRR   = 2'd2,
        ARB_RSVD  = 2'd3
    } arb_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/qos_arbiter_rr_pick.sv
// rr_pick: rotating-priority search. Returns the first set bit of mask
// found searching upward from base with wrap-around.
//   mask   - candidate request mask
//   base   - starting index of the search (must be < N)
//   onehot - one-hot winner (zero when nothing found)
//   idx    - binary winner index (zero when nothing found)
//   found  - high when any mask bit is set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(base) + i) % N;
            if (!found && mask[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/qos_arbiter.sv
// qos_arbiter: multi-policy request arbiter with a held grant.
// A grant is issued one cycle after arbitration and held until done; on done
// the next winner is presented on the following edge with no idle bubble.
// Policies (mode): 0 round-robin, 1 fixed priority (highest index wins),
// 2 weighted round-robin with per-channel credits, 3 behaves as 0.
// Optional feature macro QOS_ARB_STARVE_EN adds per-channel age counters;
// a channel aged to STARVE_LIMIT overrides the policy at the next arbitration.
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   mode         - policy, sampled only in arbitration cycles
//   req          - per-channel request levels
//   weight       - packed weights, channel i at [i*WEIGHT_W +: WEIGHT_W]
//   done         - current holder finished; releases the grant
//   grant        - registered one-hot grant
//   grant_id     - index of granted channel
//   grant_valid  - any grant held
//   fsm_state    - current FSM state, for observation
module qos_arbiter
    import qos_arb_pkg::*;
#(
    parameter  int CHANNELS     = 4,
    parameter  int WEIGHT_W     = 4,
    parameter  int STARVE_LIMIT = 16,
    localparam int IW           = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*WEIGHT_W-1:0] weight,
    input  logic                         done,
    output logic [CHANNELS-1:0]          grant,
    output logic [IW-1:0]                grant_id,
    output logic                         grant_valid,
    output arb_state_e                   fsm_state
);

    arb_state_e state, state_next;
    arb_mode_e  mode_e;

    logic [IW-1:0]                      ptr, ptr_next;
    logic [CHANNELS-1:0][WEIGHT_W-1:0]  credit, credit_next, credit_base;
    logic [CHANNELS-1:0]                credit_nz;
    logic                               reload;
    logic                               arb_now;
    logic                               any_req;

    logic [CHANNELS-1:0] pick_mask, pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_found;

    logic [CHANNELS-1:0] fixed_onehot;
    logic [IW-1:0]       fixed_idx;

    logic [CHANNELS-1:0] win_onehot;
    logic [IW-1:0]       win_idx;

    assign mode_e  = arb_mode_e'(mode);
    assign any_req = |req;
    // Arbitration happens when idle with requests, or when the holder signals done.
    assign arb_now = ((state == ST_IDLE) && any_req) || ((state == ST_BUSY) && done);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_req)         state_next = ST_BUSY;
            ST_BUSY: if (done && !any_req) state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        grant_valid = |grant;
        fsm_state   = state;
    end

    // ---------------- WRR credit view ----------------
    // When no requester holds credit, every credit is reloaded and the same
    // cycle arbitrates over the reloaded values (weight 0 counts as 1).
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            credit_nz[i] = (credit[i] != '0);
        end
        reload = ~|(req & credit_nz);
        for (int i = 0; i < CHANNELS; i++) begin
            if (reload)
                credit_base[i] = (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                                 WEIGHT_W'(1) : weight[i*WEIGHT_W +: WEIGHT_W];
            else
                credit_base[i] = credit[i];
        end
    end

    assign pick_mask = (mode_e == ARB_WRR) ? (reload ? req : (req & credit_nz)) : req;

    rr_pick #(.N(CHANNELS), .IW(IW)) u_rr_pick (
        .mask   (pick_mask),
        .base   (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // Fixed priority: highest requesting index.
    always_comb begin
        fixed_idx    = '0;
        fixed_onehot = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (req[i]) fixed_idx = IW'(i);
        end
        if (any_req) fixed_onehot[fixed_idx] = 1'b1;
    end

`ifdef QOS_ARB_STARVE_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [CHANNELS-1:0][AGE_W-1:0] age;
    logic [CHANNELS-1:0]            starve_onehot;
    logic [IW-1:0]                  starve_idx;
    logic                           starve_any;

    // Lowest-index starved requester.
    always_comb begin
        starve_onehot = '0;
        starve_idx    = '0;
        starve_any    = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i] && (age[i] == AGE_W'(STARVE_LIMIT))) begin
                starve_any = 1'b1;
                starve_idx = IW'(i);
            end
        end
        if (starve_any) starve_onehot[starve_idx] = 1'b1;
    end

    // Age clears when the channel is holding or winning the grant, so a
    // starved winner cannot immediately re-trigger the override.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!req[i] || grant[i] || (arb_now && win_onehot[i]))
                    age[i] <= '0;
                else if (age[i] != AGE_W'(STARVE_LIMIT))
                    age[i] <= age[i] + AGE_W'(1);
            end
        end
    end
`endif

    // ---------------- winner selection ----------------
    always_comb begin
        win_onehot  = '0;
        win_idx     = '0;
        ptr_next    = ptr;
        credit_next = credit;
        if (any_req) begin
`ifdef QOS_ARB_STARVE_EN
            if (starve_any) begin
                win_onehot = starve_onehot;
                win_idx    = starve_idx;
                ptr_next   = IW'(wrap_inc(int'(starve_idx), CHANNELS));
            end else
`endif
            begin
                case (mode_e)
                    ARB_FIXED: begin
                        win_onehot = fixed_onehot;
                        win_idx    = fixed_idx;
                    end
                    ARB_WRR: begin
                        if (pick_found) begin
                            win_onehot            = pick_onehot;
                            win_idx               = pick_idx;
                            credit_next           = credit_base;
                            credit_next[pick_idx] = credit_base[pick_idx] - WEIGHT_W'(1);
                            // Stay on this channel until its credit is spent.
                            if (credit_base[pick_idx] == WEIGHT_W'(1))
                                ptr_next = IW'(wrap_inc(int'(pick_idx), CHANNELS));
                        end
                    end
                    default: begin
                        if (pick_found) begin
                            win_onehot = pick_onehot;
                            win_idx    = pick_idx;
                            ptr_next   = IW'(wrap_inc(int'(pick_idx), CHANNELS));
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- grant / pointer / credit registers ----------------
    // Only arbitration cycles update anything, so a held grant is immune to
    // req and mode changes. done with no requests loads an all-zero winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
            credit   <= '0;
        end else if (arb_now) begin
            grant    <= win_onehot;
            grant_id <= win_idx;
            ptr      <= ptr_next;
            credit   <= credit_next;
        end
    end

endmodule
